// File: rtl/wdata_chan_mngr_pkg.sv
// Shared write-data channel definitions for the manager (wdata_chan_mngr) and
// the subordinate (wdata_chan_subo). The state codes are also exported as
// defines so that both sides and any bus monitors decode them identically.
// Optional feature macro used by the channel modules: WDATA_WSTRB_EN.
`ifndef WDAT_DEFS_DONE
`define WDAT_DEFS_DONE
// manager states
`define WDAT_MIDLE 3'b000
`define WDAT_MSEND 3'b001
`define WDAT_MLAST 3'b010
`define WDAT_MDEFO 3'b111
// subordinate states
`define WDAT_SIDLE 3'b000
`define WDAT_SRECV 3'b001
`define WDAT_SDEFO 3'b111
// beat width / max beats per burst
`define WDAT_DW    32
`define WDAT_NBEAT 4
`endif

package wdata_chan_mngr_pkg;
  localparam int DW     = `WDAT_DW;
  localparam int NBEAT  = `WDAT_NBEAT;
  localparam int LINE_W = DW * NBEAT;
  localparam int BE_W   = LINE_W / 8;

  typedef enum logic [2:0] {
    MIDLE = `WDAT_MIDLE,
    MSEND = `WDAT_MSEND,
    MLAST = `WDAT_MLAST,
    MDEFO = `WDAT_MDEFO
  } mstate_e;

  // Next-state decode. Unknown encodings (and MDEFO) hold until reset.
  function automatic mstate_e mngr_next(input mstate_e st, input logic start,
                                        input logic [1:0] len, input logic wready,
                                        input logic [1:0] cntr);
    mstate_e nx;
    nx = st;
    case (st)
      MIDLE: if (start) nx = (len == 2'd0) ? MLAST : MSEND;
      MSEND: if (wready) nx = (2'(cntr + 2'd1) == len) ? MLAST : MSEND;
      MLAST: if (wready) nx = MIDLE;
      default: nx = st;
    endcase
    return nx;
  endfunction
endpackage

// File: rtl/wdata_chan_mngr.sv
// wdata_chan_mngr: manager side of the write data channel. Captures a 128-bit
// line and beat count on start_wd, serialises it as 1-4 32-bit beats on
// wvalid/wready/wdata/wlast, and pulses finish_mwd the cycle after the last
// beat handshake.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start_wd/wd_data/wd_len  request (accepted only while wd_ready)
//   wd_ready              idle, request will be accepted
//   finish_mwd            registered one-cycle done pulse
//   wvalid/wready/wdata/wlast  write data channel
//   wd_be/wstrb           byte enables / per-beat strobes (WDATA_WSTRB_EN only)
// Macro: WDATA_WSTRB_EN adds the byte-enable path.
module wdata_chan_mngr
  import wdata_chan_mngr_pkg::*;
#(
  parameter int DW    = 32,
  parameter int NBEAT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_wd,
  input  logic [DW*NBEAT-1:0]   wd_data,
  input  logic [1:0]            wd_len,
  output logic                  wd_ready,
  output logic                  finish_mwd,
`ifdef WDATA_WSTRB_EN
  input  logic [DW*NBEAT/8-1:0] wd_be,
  output logic [DW/8-1:0]       wstrb,
`endif
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DW-1:0]         wdata,
  output logic                  wlast
);

  mstate_e              state_q, state_d;
  logic [1:0]           beat_cntr_q, beat_cntr_d;
  logic [DW*NBEAT-1:0]  line_q, line_d;
  logic [1:0]           len_q, len_d;
  logic                 finish_q, finish_d;
`ifdef WDATA_WSTRB_EN
  logic [DW*NBEAT/8-1:0] be_q, be_d;
`endif

  always_comb begin
    state_d     = mngr_next(state_q, start_wd, len_q == 2'd0 ? wd_len : wd_len,
                            wready, beat_cntr_q);
    beat_cntr_d = beat_cntr_q;
    line_d      = line_q;
    len_d       = len_q;
    finish_d    = 1'b0;
`ifdef WDATA_WSTRB_EN
    be_d        = be_q;
`endif
    case (state_q)
      MIDLE: if (start_wd) begin
        line_d      = wd_data;
        len_d       = wd_len;
        beat_cntr_d = 2'd0;
`ifdef WDATA_WSTRB_EN
        be_d        = wd_be;
`endif
      end
      MSEND: begin
        // MSEND->MLAST compares against the captured length, not the live input
        state_d = mngr_next(state_q, 1'b0, len_q, wready, beat_cntr_q);
        if (wready) beat_cntr_d = beat_cntr_q + 2'd1;
      end
      MLAST: if (wready) finish_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MIDLE;
      beat_cntr_q <= 2'd0;
      line_q      <= '0;
      len_q       <= 2'd0;
      finish_q    <= 1'b0;
`ifdef WDATA_WSTRB_EN
      be_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      beat_cntr_q <= beat_cntr_d;
      line_q      <= line_d;
      len_q       <= len_d;
      finish_q    <= finish_d;
`ifdef WDATA_WSTRB_EN
      be_q        <= be_d;
`endif
    end
  end

  // Channel outputs decode only registered state, so they are glitch-free and
  // hold still while the subordinate stalls.
  assign wvalid     = (state_q == MSEND) || (state_q == MLAST);
  assign wlast      = (state_q == MLAST);
  assign wd_ready   = (state_q == MIDLE);
  assign finish_mwd = finish_q;
  assign wdata      = line_q[DW*beat_cntr_q +: DW];
`ifdef WDATA_WSTRB_EN
  assign wstrb      = wvalid ? be_q[(DW/8)*beat_cntr_q +: DW/8] : '0;
`endif

endmodule

// File: tb/tb_wdata_chan_mngr.sv
module tb_wdata_chan_mngr;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_wd;
  logic [127:0] wd_data;
  logic [1:0]   wd_len;
  logic         wd_ready;
  logic         finish_mwd;
  logic         wvalid;
  logic         wready;
  logic [31:0]  wdata;
  logic         wlast;
`ifdef WDATA_WSTRB_EN
  logic [15:0]  wd_be;
  logic [3:0]   wstrb;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wdata_chan_mngr dut (
    .clk(clk), .rst_n(rst_n), .start_wd(start_wd), .wd_data(wd_data),
    .wd_len(wd_len), .wd_ready(wd_ready), .finish_mwd(finish_mwd),
`ifdef WDATA_WSTRB_EN
    .wd_be(wd_be), .wstrb(wstrb),
`endif
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 4-beat burst with wready held high (also used after a mid-burst reset)
  task automatic burst4(input string tag);
    logic [31:0] words [4];
    words[0] = 32'h11111111; words[1] = 32'h22222222;
    words[2] = 32'h33333333; words[3] = 32'h44444444;
    start_wd = 1'b1; wd_len = 2'd3; wready = 1'b1;
    wd_data = 128'h44444444_33333333_22222222_11111111;
`ifdef WDATA_WSTRB_EN
    wd_be = 16'hF03C;
`endif
    tick();
    start_wd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_wvalid"}, 32'(wvalid), 32'd1);
      check({tag, "_wdata"}, wdata, words[i]);
      check({tag, "_wlast"}, 32'(wlast), (i == 3) ? 32'd1 : 32'd0);
      check({tag, "_busy"}, 32'(wd_ready), 32'd0);
`ifdef WDATA_WSTRB_EN
      begin
        logic [15:0] be_exp;
        be_exp = 16'hF03C;
        check({tag, "_wstrb"}, 32'(wstrb), 32'(be_exp[4*i +: 4]));
      end
`endif
      check({tag, "_nofin"}, 32'(finish_mwd), 32'd0);
      tick();
    end
    check({tag, "_finish"}, 32'(finish_mwd), 32'd1);
    check({tag, "_idle_wvalid"}, 32'(wvalid), 32'd0);
    check({tag, "_ready"}, 32'(wd_ready), 32'd1);
    tick();
    check({tag, "_fin_pulse"}, 32'(finish_mwd), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_d [6];
    logic        exp_l [6];
    logic        wr_seq [6];

    rst_n = 1'b0; start_wd = 1'b0; wd_data = '0; wd_len = 2'd0; wready = 1'b0;
`ifdef WDATA_WSTRB_EN
    wd_be = 16'hFFFF;
`endif
    #12;
    // 1: reset state and idle
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_wlast", 32'(wlast), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_ready", 32'(wd_ready), 32'd1);
    check("rst_finish", 32'(finish_mwd), 32'd0);
`ifdef WDATA_WSTRB_EN
    check("rst_wstrb", 32'(wstrb), 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      wready = i[0];
      check("idle_wvalid", 32'(wvalid), 32'd0);
      check("idle_ready", 32'(wd_ready), 32'd1);
      check("idle_finish", 32'(finish_mwd), 32'd0);
      tick();
    end

    // 2: full 4-beat burst
    burst4("b4");

    // 3: single beat
    start_wd = 1'b1; wd_len = 2'd0; wready = 1'b1;
    wd_data = 128'h0; wd_data[31:0] = 32'hDEADBEEF;
    tick();
    start_wd = 1'b0;
    check("b1_wvalid", 32'(wvalid), 32'd1);
    check("b1_wlast", 32'(wlast), 32'd1);
    check("b1_wdata", wdata, 32'hDEADBEEF);
    tick();
    check("b1_finish", 32'(finish_mwd), 32'd1);
    check("b1_wvalid_off", 32'(wvalid), 32'd0);
    tick();

    // 4: 3 beats with stalls, wready 1,0,0,1,0,1
    exp_d[0] = 32'hC0000000; exp_d[1] = 32'hC0000001; exp_d[2] = 32'hC0000001;
    exp_d[3] = 32'hC0000001; exp_d[4] = 32'hC0000002; exp_d[5] = 32'hC0000002;
    exp_l[0] = 0; exp_l[1] = 0; exp_l[2] = 0; exp_l[3] = 0; exp_l[4] = 1; exp_l[5] = 1;
    wr_seq[0] = 1; wr_seq[1] = 0; wr_seq[2] = 0; wr_seq[3] = 1; wr_seq[4] = 0; wr_seq[5] = 1;
    start_wd = 1'b1; wd_len = 2'd2; wready = 1'b0;
    wd_data = 128'hFFFFFFFF_C0000002_C0000001_C0000000;
    tick();
    start_wd = 1'b0; wd_data = '0; wd_len = 2'd0;
    for (int i = 0; i < 6; i++) begin
      check("st_wvalid", 32'(wvalid), 32'd1);
      check("st_wdata", wdata, exp_d[i]);
      check("st_wlast", 32'(wlast), 32'(exp_l[i]));
      check("st_nofin", 32'(finish_mwd), 32'd0);
      wready = wr_seq[i];
      tick();
    end
    check("st_finish", 32'(finish_mwd), 32'd1);
    wready = 1'b0;
    tick();

    // 5: start during burst ignored; start in finish cycle accepted
    start_wd = 1'b1; wd_len = 2'd1; wready = 1'b1;
    wd_data = 128'h0000000B_0000000A;
    tick();
    wd_data = 128'h77777777_77777777; wd_len = 2'd3;  // start_wd still high: must be ignored
    check("bb_b0", wdata, 32'h0000000A);
    tick();
    check("bb_b1", wdata, 32'h0000000B);
    check("bb_b1_last", 32'(wlast), 32'd1);
    start_wd = 1'b0;
    tick();
    check("bb_finish", 32'(finish_mwd), 32'd1);
    check("bb_ready", 32'(wd_ready), 32'd1);
    start_wd = 1'b1; wd_len = 2'd0; wd_data = 128'h55;
    tick();
    start_wd = 1'b0;
    check("bb2_wvalid", 32'(wvalid), 32'd1);
    check("bb2_wdata", wdata, 32'h00000055);
    check("bb2_wlast", 32'(wlast), 32'd1);
    tick();
    check("bb2_finish", 32'(finish_mwd), 32'd1);
    tick();

    // 6: reset during beat 2 of 4
    start_wd = 1'b1; wd_len = 2'd3; wready = 1'b1;
    wd_data = 128'h44444444_33333333_22222222_11111111;
    tick();
    start_wd = 1'b0;
    tick();
    check("ab_beat2", wdata, 32'h22222222);
    rst_n = 1'b0;
    #1;
    check("ab_wvalid", 32'(wvalid), 32'd0);
    check("ab_ready", 32'(wd_ready), 32'd1);
    tick();
    check("ab_nofin", 32'(finish_mwd), 32'd0);
    rst_n = 1'b1;
    tick();
    check("ab_nofin2", 32'(finish_mwd), 32'd0);
    check("ab_idle", 32'(wvalid), 32'd0);
    burst4("rb4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
